// File: rtl/seq_run_detector_pkg.sv
// rtl/seq_run_detector_pkg.sv - shared constants and helpers for the run-length detector
package seq_run_detector_pkg;

    localparam int DEF_W = 2;
    localparam int DEF_N = 3;
    localparam int K_W   = $clog2(DEF_N + 1);

    // Elements 1,2,3 with element 0 in the low bits
    localparam logic [DEF_N*DEF_W-1:0] DEF_PAT = 6'b111001;

    // Active pattern length is always at least one element and never beyond N
    function automatic int clamp_len(input int len, input int n);
        if (len < 1) begin
            return 1;
        end
        if (len > n) begin
            return n;
        end
        return len;
    endfunction

endpackage

// File: rtl/seq_run_detector_sat_counter.sv
// rtl/seq_run_detector_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    // Clear beats increment; the count sticks at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_run_detector.sv
// rtl/seq_run_detector.sv - programmable run-length pattern detector with hit counter
module seq_run_detector
    import seq_run_detector_pkg::*;
#(
    parameter int                 W       = DEF_W,
    parameter int                 N       = DEF_N,
    parameter int                 CNT_W   = 8,
    parameter logic [N*W-1:0]     RST_PAT = DEF_PAT,
    localparam int                IDX_W   = (N > 1) ? $clog2(N) : 1,
    localparam int                LEN_W   = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [W-1:0]     in_sym,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [W-1:0]     cfg_sym,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             clr_cnt,
    output logic             match,
    output logic             hit,
    output logic [CNT_W-1:0] hit_cnt
);

    logic [LEN_W-1:0] k;
    logic [LEN_W-1:0] k_next;
    logic [LEN_W-1:0] len;
    logic [W-1:0]     pat [N];
    logic [W-1:0]     sym_cur;
    logic [W-1:0]     sym_prev;
    logic             hit_set;

    // Select the element awaited next (pat[k]) and the one last matched (pat[k-1])
    always_comb begin
        sym_cur  = '0;
        sym_prev = '0;
        for (int i = 0; i < N; i++) begin
            if (k == LEN_W'(i)) begin
                sym_cur = pat[i];
            end
            if (k == LEN_W'(i + 1)) begin
                sym_prev = pat[i];
            end
        end
    end

    // Advance, repeat, restart, else drop to zero, in that priority
    always_comb begin
        k_next = k;
        if ((k < len) && (in_sym == sym_cur)) begin
            k_next = k + LEN_W'(1);
        end else if ((k != '0) && (in_sym == sym_prev)) begin
            k_next = k;
        end else if (in_sym == pat[0]) begin
            k_next = LEN_W'(1);
        end else begin
            k_next = '0;
        end
    end

    // A hit is only the transition into the full-match state
    assign hit_set = in_valid && !cfg_we && (k != len) && (k_next == len);
    assign match   = (k == len);

    // Progress state, active length and pattern storage; config discards any symbol
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k   <= '0;
            len <= LEN_W'(N);
            for (int i = 0; i < N; i++) begin
                pat[i] <= RST_PAT[i*W +: W];
            end
        end else if (cfg_we) begin
            k   <= '0;
            len <= LEN_W'(clamp_len(int'(cfg_len), N));
            for (int i = 0; i < N; i++) begin
                if (cfg_idx == IDX_W'(i)) begin
                    pat[i] <= cfg_sym;
                end
            end
        end else if (in_valid) begin
            k <= k_next;
        end
    end

    // One-cycle hit pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit <= 1'b0;
        end else begin
            hit <= hit_set;
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_hit_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (hit_set),
        .clr  (clr_cnt),
        .cnt  (hit_cnt)
    );

endmodule
